// File: rtl/ldl_sfifo_pkg.sv
// Shared types, defaults and flag helper for the multi-channel sync FIFO controller.
package ldl_sfifo_pkg;

    localparam int DEF_NCH       = 4;
    localparam int DEF_AWIDTH    = 6;
    localparam int DEF_AE_TH     = 2;
    // Default almost-full threshold is depth minus this margin.
    localparam int DEF_AF_MARGIN = 2;

    // Pointers of any AWIDTH are zero-extended into this carrier so one
    // helper serves every parameterisation; bit AWIDTH is the wrap bit.
    localparam int PTR_MAXW = 32;
    typedef logic [PTR_MAXW-1:0] ptr_w_t;

    typedef struct packed {
        logic full;
        logic empty;
    } ptr_flags_t;

    // Full: wrap bits differ, low bits equal. Empty: pointers equal.
    function automatic ptr_flags_t ptr_flags(input ptr_w_t wp, input ptr_w_t rp, input int aw);
        ptr_w_t     diff;
        ptr_w_t     lo_mask;
        ptr_flags_t f;
        diff    = wp ^ rp;
        lo_mask = (ptr_w_t'(1) << aw) - ptr_w_t'(1);
        f.empty = ((diff & ((lo_mask << 1) | ptr_w_t'(1))) == '0);
        f.full  = ((diff & lo_mask) == '0) && diff[aw];
        return f;
    endfunction

endpackage

// File: rtl/ldl_sfifo_ptr.sv
// One channel's write/read pointer pair, occupancy and full/empty/almost flags.
module ldl_sfifo_ptr
    import ldl_sfifo_pkg::*;
#(
    parameter int AWIDTH = DEF_AWIDTH,
    parameter int AF_TH  = (1 << AWIDTH) - DEF_AF_MARGIN,
    parameter int AE_TH  = DEF_AE_TH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_inc,
    input  logic              rd_inc,
    output logic              full,
    output logic              empty,
    output logic              afull,
    output logic              aempty,
    output logic [AWIDTH-1:0] wptr,
    output logic [AWIDTH-1:0] rptr,
    output logic [AWIDTH:0]   count
);

    typedef logic [AWIDTH:0] ptr_t;
    localparam ptr_t AF_C = ptr_t'(AF_TH);
    localparam ptr_t AE_C = ptr_t'(AE_TH);

    ptr_t       wptr_q, wptr_d, rptr_q, rptr_d, cnt_d;
    logic       afull_q, afull_d, aempty_q, aempty_d;
    ptr_flags_t fl;

    // Pointer advance and next-state almost flags (flags look at the post-edge count).
    always_comb begin
        fl       = ptr_flags(ptr_w_t'(wptr_q), ptr_w_t'(rptr_q), AWIDTH);
        wptr_d   = wptr_q + ptr_t'(wr_inc);
        rptr_d   = rptr_q + ptr_t'(rd_inc);
        cnt_d    = wptr_d - rptr_d;
        afull_d  = (cnt_d >= AF_C);
        aempty_d = (cnt_d <= AE_C);
    end

    // Pointer and almost-flag registers; reset leaves the channel empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
        end
    end

    assign full   = fl.full;
    assign empty  = fl.empty;
    assign afull  = afull_q;
    assign aempty = aempty_q;
    assign wptr   = wptr_q[AWIDTH-1:0];
    assign rptr   = rptr_q[AWIDTH-1:0];
    assign count  = wptr_q - rptr_q;

endmodule

// File: rtl/ldl_sfifo_ctr_mc.sv
// Multi-channel sync FIFO controller over one shared RAM (one region per channel).
// Optional sticky overflow/underflow flags: define LDL_SFIFO_MC_STAT_EN.
module ldl_sfifo_ctr_mc
    import ldl_sfifo_pkg::*;
#(
    parameter int NCH    = DEF_NCH,
    parameter int AWIDTH = DEF_AWIDTH,
    parameter int AF_TH  = (1 << AWIDTH) - DEF_AF_MARGIN,
    parameter int AE_TH  = DEF_AE_TH,
    parameter int CWIDTH = $clog2(NCH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [CWIDTH-1:0]        wch,
    input  logic                     re,
    input  logic [CWIDTH-1:0]        rch,
    output logic [NCH-1:0]           full,
    output logic [NCH-1:0]           empty,
    output logic [NCH-1:0]           afull,
    output logic [NCH-1:0]           aempty,
    output logic [CWIDTH+AWIDTH-1:0] wa,
    output logic [CWIDTH+AWIDTH-1:0] ra,
    output logic                     mw,
    output logic                     mr,
    output logic                     rvalid,
    output logic [CWIDTH-1:0]        rvch,
    output logic [AWIDTH:0]          count,
    output logic [NCH-1:0]           ovf,
    output logic [NCH-1:0]           udf
);

    logic [NCH-1:0]             wr_inc, rd_inc;
    logic [NCH-1:0][AWIDTH-1:0] wptr_v, rptr_v;
    logic [NCH-1:0][AWIDTH:0]   cnt_v;
    logic                       wfull_sel, rempty_sel, fw, fr;
    logic [AWIDTH-1:0]          wptr_sel, rptr_sel;
    logic [AWIDTH:0]            cnt_sel;
    logic                       rvalid_q, rvalid_d;
    logic [CWIDTH-1:0]          rvch_q, rvch_d;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        ldl_sfifo_ptr #(
            .AWIDTH (AWIDTH),
            .AF_TH  (AF_TH),
            .AE_TH  (AE_TH)
        ) u_ptr (
            .clk    (clk),
            .rst    (rst),
            .wr_inc (wr_inc[c]),
            .rd_inc (rd_inc[c]),
            .full   (full[c]),
            .empty  (empty[c]),
            .afull  (afull[c]),
            .aempty (aempty[c]),
            .wptr   (wptr_v[c]),
            .rptr   (rptr_v[c]),
            .count  (cnt_v[c])
        );
    end

    // Channel muxing and accept decode; an index with no channel reads as full/empty.
    always_comb begin
        wfull_sel  = 1'b1;
        rempty_sel = 1'b1;
        wptr_sel   = '0;
        rptr_sel   = '0;
        cnt_sel    = '0;
        wr_inc     = '0;
        rd_inc     = '0;
        for (int c = 0; c < NCH; c++) begin
            if (wch == CWIDTH'(c)) begin
                wfull_sel = full[c];
                wptr_sel  = wptr_v[c];
            end
            if (rch == CWIDTH'(c)) begin
                rempty_sel = empty[c];
                rptr_sel   = rptr_v[c];
                cnt_sel    = cnt_v[c];
            end
        end
        fw = we & ~wfull_sel;
        fr = re & ~rempty_sel;
        for (int c = 0; c < NCH; c++) begin
            wr_inc[c] = fw & (wch == CWIDTH'(c));
            rd_inc[c] = fr & (rch == CWIDTH'(c));
        end
        rvalid_d = fr;
        rvch_d   = fr ? rch : rvch_q;
    end

    // Read-data-valid stage matching the RAM's one-cycle read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rvch_q   <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            rvch_q   <= rvch_d;
        end
    end

    assign mw     = fw;
    assign mr     = fr;
    assign wa     = {wch, wptr_sel};
    assign ra     = {rch, rptr_sel};
    assign count  = cnt_sel;
    assign rvalid = rvalid_q;
    assign rvch   = rvch_q;

`ifdef LDL_SFIFO_MC_STAT_EN
    logic [NCH-1:0] ovf_q, ovf_d, udf_q, udf_d;

    // Sticky flags for requests refused because the addressed channel was full/empty.
    always_comb begin
        ovf_d = ovf_q;
        udf_d = udf_q;
        for (int c = 0; c < NCH; c++) begin
            if (we && (wch == CWIDTH'(c)) && full[c])  ovf_d[c] = 1'b1;
            if (re && (rch == CWIDTH'(c)) && empty[c]) udf_d[c] = 1'b1;
        end
    end

    // Flag registers, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= '0;
            udf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign ovf = ovf_q;
    assign udf = udf_q;
`else
    assign ovf = '0;
    assign udf = '0;
`endif

endmodule

// File: tb/tb_ldl_sfifo_ctr_mc.sv
// Randomised/directed bench for ldl_sfifo_ctr_mc with an occupancy-based model and rvalid scoreboard.
module tb_ldl_sfifo_ctr_mc;

    localparam int NCH   = 4;
    localparam int AW    = 6;
    localparam int CW    = 2;
    localparam int DEPTH = 1 << AW;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;

    logic              clk = 1'b0;
    logic              rst, we, re;
    logic [CW-1:0]     wch, rch;
    logic [NCH-1:0]    full, empty, afull, aempty, ovf, udf;
    logic [CW+AW-1:0]  wa, ra;
    logic              mw, mr, rvalid;
    logic [CW-1:0]     rvch;
    logic [AW:0]       count;

    ldl_sfifo_ctr_mc #(.NCH(NCH), .AWIDTH(AW)) dut (
        .clk(clk), .rst(rst), .we(we), .wch(wch), .re(re), .rch(rch),
        .full(full), .empty(empty), .afull(afull), .aempty(aempty),
        .wa(wa), .ra(ra), .mw(mw), .mr(mr), .rvalid(rvalid), .rvch(rvch),
        .count(count), .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    // Model: occupancy per channel plus free-running write/read positions.
    int cnt[NCH];
    int wpos[NCH];
    int rpos[NCH];
    bit m_af[NCH], m_ae[NCH], m_ovf[NCH], m_udf[NCH];
    int rq[$];
    bit mon_en = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            cnt[c] = 0; wpos[c] = 0; rpos[c] = 0;
            m_af[c] = 1'b0; m_ae[c] = 1'b1; m_ovf[c] = 1'b0; m_udf[c] = 1'b0;
        end
    endtask

    // One clock cycle: drive, check pre-edge outputs at negedge, advance the model at posedge.
    task automatic step(input bit r, input bit w, input int wc, input bit rd, input int rc);
        bit             efw, efr;
        logic [NCH-1:0] ef, ee, eaf, eae, eov, eud;
        rst = r; we = w; wch = CW'(wc); re = rd; rch = CW'(rc);
        @(negedge clk);
        efw = w && (cnt[wc] < DEPTH);
        efr = rd && (cnt[rc] > 0);
        for (int c = 0; c < NCH; c++) begin
            ef[c]  = (cnt[c] == DEPTH);
            ee[c]  = (cnt[c] == 0);
            eaf[c] = m_af[c];
            eae[c] = m_ae[c];
            eov[c] = m_ovf[c];
            eud[c] = m_udf[c];
        end
        chk("mw", longint'(mw), longint'(efw));
        chk("mr", longint'(mr), longint'(efr));
        if (efw) chk("wa", longint'(wa), longint'((wc << AW) | (wpos[wc] % DEPTH)));
        if (efr) chk("ra", longint'(ra), longint'((rc << AW) | (rpos[rc] % DEPTH)));
        chk("count", longint'(count), longint'(cnt[rc]));
        chk("full", longint'(full), longint'(ef));
        chk("empty", longint'(empty), longint'(ee));
        chk("afull", longint'(afull), longint'(eaf));
        chk("aempty", longint'(aempty), longint'(eae));
        chk("ovf", longint'(ovf), longint'(eov));
        chk("udf", longint'(udf), longint'(eud));
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
`ifdef LDL_SFIFO_MC_STAT_EN
            if (w && cnt[wc] == DEPTH) m_ovf[wc] = 1'b1;
            if (rd && cnt[rc] == 0) m_udf[rc] = 1'b1;
`endif
            if (efw) begin cnt[wc]++; wpos[wc]++; end
            if (efr) begin cnt[rc]--; rpos[rc]++; rq.push_back(rc); end
            for (int c = 0; c < NCH; c++) begin
                m_af[c] = (cnt[c] >= AF);
                m_ae[c] = (cnt[c] <= AE);
            end
        end
        #1;
    endtask

    task automatic rnd_steps(input int n, input int wprob, input int rprob);
        for (int i = 0; i < n; i++)
            step(1'b0, ($urandom_range(0, 99) < wprob), $urandom_range(0, NCH-1),
                 ($urandom_range(0, 99) < rprob), $urandom_range(0, NCH-1));
    endtask

    // Scoreboard monitor: each accepted read must show rvalid with its channel one cycle later.
    initial begin
        int  e;
        bit  ev;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                ev = (rq.size() != 0);
                chk("rvalid", longint'(rvalid), longint'(ev));
                if (ev) begin
                    e = rq.pop_front();
                    if (rvalid === 1'b1) chk("rvch", longint'(rvch), longint'(e));
                end
            end
        end
    end

    initial begin
        rst = 1'b1; we = 1'b0; re = 1'b0; wch = '0; rch = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
        chk("rvch_rst", longint'(rvch), 0);

        // Fill ch0 to full, then one refused write.
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 1'b1, 0, 1'b0, 1);

        // Writes alternate ch1/ch2 while ch1 is read every cycle.
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1 + (i % 2), 1'b1, 1);

        // Fill ch3, then simultaneous write+read on the full channel.
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 3, 1'b0, 3);
        step(1'b0, 1'b1, 3, 1'b1, 3);
        step(1'b0, 1'b0, 0, 1'b0, 3);

        // Drain ch0 with one extra read, then simultaneous write+read on the empty channel.
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 1'b0, 0, 1'b1, 0);
        step(1'b0, 1'b1, 0, 1'b1, 0);
        step(1'b0, 1'b0, 0, 1'b0, 0);

        // Drain ch2, then 200 write/read pairs across the pointer wrap.
        for (int i = 0; i < 2 * DEPTH && cnt[2] > 0; i++) step(1'b0, 1'b0, 0, 1'b1, 2);
        for (int i = 0; i < 200; i++) step(1'b0, 1'b1, 2, (cnt[2] > 0), 2);

        // Random traffic, write-heavy then read-heavy.
        rnd_steps(500, 75, 30);
        rnd_steps(500, 30, 75);
        rnd_steps(300, 60, 60);

        // Mid-stream reset with a read in flight, then more traffic.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1, 1'b0, 1);
        step(1'b0, 1'b0, 0, 1'b1, 1);
        step(1'b1, 1'b1, 1, 1'b1, 1);
        chk("rvch_midrst", longint'(rvch), 0);
        rnd_steps(300, 55, 50);

        repeat (3) step(1'b0, 1'b0, 0, 1'b0, 0);
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
